// File: rtl/ni_target_resp_router_if.sv
// rtl/ni_target_resp_router_if.sv - request capture / response route bundle for the NI target response router.
// err_count is present only when NI_TGT_ROUTE_ERRCNT_EN is defined.
interface ni_target_resp_router_if #(
    parameter int SRC_W  = 4,
    parameter int TID_W  = 4,
    parameter int PATH_W = 7
);
    logic              req_valid;
    logic              req_ready;
    logic [SRC_W-1:0]  req_source;
    logic [TID_W-1:0]  req_tid;
    logic              route_valid;
    logic              route_ready;
    logic [PATH_W-1:0] route_path;
    logic [SRC_W-1:0]  route_dest;
    logic [TID_W-1:0]  route_tid;
    logic              failed_decoding;
    logic [4:0]        outstanding;
`ifdef NI_TGT_ROUTE_ERRCNT_EN
    logic [7:0]        err_count;
`endif

    modport master (
        output req_valid, req_source, req_tid, route_ready,
        input  req_ready, route_valid, route_path, route_dest, route_tid,
        input  failed_decoding,
`ifdef NI_TGT_ROUTE_ERRCNT_EN
        input  err_count,
`endif
        input  outstanding
    );

    modport slave (
        input  req_valid, req_source, req_tid, route_ready,
        output req_ready, route_valid, route_path, route_dest, route_tid,
        output failed_decoding,
`ifdef NI_TGT_ROUTE_ERRCNT_EN
        output err_count,
`endif
        output outstanding
    );
endinterface

// File: rtl/ni_target_resp_router.sv
// rtl/ni_target_resp_router.sv - in-order outstanding-transaction FIFO returning response routes to initiators.
// Optional decode-error counter enabled by NI_TGT_ROUTE_ERRCNT_EN.
module ni_target_resp_router #(
    parameter int DEPTH  = 4,
    parameter int SRC_W  = 4,
    parameter int TID_W  = 4,
    parameter int PATH_W = 7
) (
    input logic                    clock,
    input logic                    reset,
    ni_target_resp_router_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SRC_W-1:0]  src_mem_q [DEPTH];
    logic [TID_W-1:0]  tid_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [SRC_W-1:0]  head_src;
    logic [TID_W-1:0]  head_tid;
    logic [PATH_W-1:0] head_path;
    logic              head_miss;

    // req_ready looks only at full, so a same-cycle pop never opens a slot
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.req_valid && !full;
    assign pop   = bus.route_ready && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            src_mem_q[wr_ptr_q] <= bus.req_source;
            tid_mem_q[wr_ptr_q] <= bus.req_tid;
        end
    end

    assign head_src = src_mem_q[rd_ptr_q];
    assign head_tid = tid_mem_q[rd_ptr_q];

    // Fixed return table: source ID -> hop list back to the initiator
    always_comb begin
        head_path = '0;
        head_miss = 1'b0;
        case (head_src)
            SRC_W'(4'h0): head_path = PATH_W'(7'b0000000);
            SRC_W'(4'h1): head_path = PATH_W'(7'b0000000);
            SRC_W'(4'h5): head_path = PATH_W'(7'b0000001);
            SRC_W'(4'hb): head_path = PATH_W'(7'b0000010);
            SRC_W'(4'h8): head_path = PATH_W'(7'b0000011);
            SRC_W'(4'hc): head_path = PATH_W'(7'b0000111);
            default:      head_miss = 1'b1;
        endcase
    end

    always_comb begin
        bus.route_path      = '0;
        bus.route_dest      = '0;
        bus.route_tid       = '0;
        bus.failed_decoding = 1'b0;
        if (!empty) begin
            bus.route_path      = head_path;
            bus.route_dest      = head_src;
            bus.route_tid       = head_tid;
            bus.failed_decoding = head_miss;
        end
    end

    assign bus.req_ready   = !full;
    assign bus.route_valid = !empty;
    assign bus.outstanding = 5'(count_q);

`ifdef NI_TGT_ROUTE_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (pop && head_miss && err_count_q != 8'hff) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign bus.err_count = err_count_q;
`endif
endmodule
